// File: rtl/seg_scan_scheduler.sv
// Time-multiplexed 7-segment scan scheduler: a small digit store plus an OFF/GAP/DRIVE sequencer.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg_scan_scheduler #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    output logic [3:0]        digit_value,
    output logic [DIGITS-1:0] digit_sel,
    output logic              frame_tick
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        idx_r;
    logic [2:0]        idx_nxt_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_nxt_s;
    logic [3:0]        store_r     [DIGITS];
    logic [3:0]        store_nxt_s [DIGITS];
    logic              tick_nxt_s;
    logic [DIGITS-1:0] sel_nxt_s;
    logic [3:0]        val_nxt_s;
    logic              lz_hide_s;

`ifdef LEADING_ZERO_BLANK_EN
    // True when any digit at index `from` or above holds a nonzero value.
    function automatic logic upper_nonzero(input logic [3:0] st [DIGITS], input logic [2:0] from);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((3'(i) >= from) && (st[i] != 4'd0)) begin
                nz = 1'b1;
            end else begin
                nz = nz;
            end
        end
        return nz;
    endfunction
`endif

    // Store image after this edge's write; out-of-range addresses match no entry.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (wr_en && (wr_addr == 3'(i))) begin
                store_nxt_s[i] = wr_data;
            end else begin
                store_nxt_s[i] = store_r[i];
            end
        end
    end

    // Scan sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        tick_nxt_s  = 1'b0;
        if (!enable) begin
            state_nxt_s = ST_OFF;
            idx_nxt_s   = 3'd0;
            cnt_nxt_s   = 16'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_GAP;
                    idx_nxt_s   = 3'd0;
                    cnt_nxt_s   = 16'd0;
                end
                ST_GAP: begin
                    if (cnt_r == 16'(BLANK - 1)) begin
                        state_nxt_s = ST_DRIVE;
                        cnt_nxt_s   = 16'd0;
                    end else begin
                        cnt_nxt_s = cnt_r + 16'd1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == 16'(DWELL - 1)) begin
                        state_nxt_s = ST_GAP;
                        cnt_nxt_s   = 16'd0;
                        if (idx_r == 3'(DIGITS - 1)) begin
                            idx_nxt_s  = 3'd0;
                            tick_nxt_s = 1'b1;
                        end else begin
                            idx_nxt_s = idx_r + 3'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    idx_nxt_s   = 3'd0;
                    cnt_nxt_s   = 16'd0;
                end
            endcase
        end
    end

    // Output image for the next cycle, built from next state and the post-write store.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lz_hide_s = (idx_nxt_s != 3'd0) && !upper_nonzero(store_nxt_s, idx_nxt_s);
`else
        lz_hide_s = 1'b0;
`endif
        val_nxt_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((state_nxt_s == ST_DRIVE) && !lz_hide_s && (idx_nxt_s == 3'(i))) begin
                sel_nxt_s[i] = 1'b1;
                val_nxt_s    = store_nxt_s[i];
            end else begin
                sel_nxt_s[i] = 1'b0;
            end
        end
    end

    // State, store and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_OFF;
            idx_r       <= 3'd0;
            cnt_r       <= 16'd0;
            digit_sel   <= '0;
            digit_value <= 4'd0;
            frame_tick  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                store_r[i] <= 4'd0;
            end
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
            digit_sel   <= sel_nxt_s;
            digit_value <= val_nxt_s;
            frame_tick  <= tick_nxt_s;
            for (int i = 0; i < DIGITS; i++) begin
                store_r[i] <= store_nxt_s[i];
            end
        end
    end

endmodule
